// File: rtl/regfile_pkg.sv
// Shared constants for the register file with scoreboard.
// Optional same-cycle write bypass is enabled by defining REGFILE_WRITE_BYPASS_EN.
package regfile_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 8;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, writeback, reservation and hazard status.
// Optional same-cycle write bypass is enabled by defining REGFILE_WRITE_BYPASS_EN.
interface regfile_scoreboard_if #(
  parameter int DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int DEPTH  = regfile_pkg::DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy1;
  logic              busy2;
  logic [CNT_W-1:0]  pend_cnt;
  logic              idle;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, busy1, busy2, pend_cnt, idle
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data1, rd_data2, busy1, busy2, pend_cnt, idle
  );
endinterface

// File: rtl/regfile_scoreboard_pending_tracker.sv
// Per-register pending bits plus a registered count of how many are set.
// Optional same-cycle write bypass (top level only) is enabled by defining REGFILE_WRITE_BYPASS_EN.
module pending_tracker import regfile_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  pending,
  output logic [CNT_W-1:0]  pend_cnt
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic             set_hit;
  logic             clr_hit;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] pending_next;
  logic [CNT_W-1:0] cnt_next;

  // Clear is applied before set so a new producer on the same register wins.
  always_comb begin
    set_hit      = set_en && (set_addr != ZERO);
    clr_hit      = clr_en && (clr_addr != ZERO);
    pending_next = pending;
    if (clr_hit) pending_next[clr_addr] = 1'b0;
    if (set_hit) pending_next[set_addr] = 1'b1;
    inc = set_hit && !pending[set_addr];
    dec = clr_hit && pending[clr_addr] && !(set_hit && (set_addr == clr_addr));
    cnt_next = pend_cnt;
    case ({inc, dec})
      2'b10:   cnt_next = pend_cnt + CNT_W'(1);
      2'b01:   cnt_next = pend_cnt - CNT_W'(1);
      default: cnt_next = pend_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_next;
      pend_cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with R0 hardwired to zero and a RAW-hazard scoreboard.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != ZERO)) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  pending_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.rsv_en),
    .set_addr (bus.rsv_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .pending  (pending),
    .pend_cnt (cnt)
  );

  // R0 is forced to zero on read so its storage never needs to be trusted.
  always_comb begin
    bus.rd_data1 = (bus.rd_addr1 == ZERO) ? '0 : rf[bus.rd_addr1];
    bus.rd_data2 = (bus.rd_addr2 == ZERO) ? '0 : rf[bus.rd_addr2];
    bus.busy1    = (bus.rd_addr1 != ZERO) && pending[bus.rd_addr1];
    bus.busy2    = (bus.rd_addr2 != ZERO) && pending[bus.rd_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr1) && (bus.rd_addr1 != ZERO)) begin
      bus.rd_data1 = bus.wr_data;
      bus.busy1    = 1'b0;
    end
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr2) && (bus.rd_addr2 != ZERO)) begin
      bus.rd_data2 = bus.wr_data;
      bus.busy2    = 1'b0;
    end
`endif
  end

  assign bus.pend_cnt = cnt;
  assign bus.idle     = (cnt == '0);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed steps then random traffic against an array model.
// Expectations follow REGFILE_WRITE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW = 24;
  localparam int DP = 8;
  localparam int AW = $clog2(DP);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
  regfile_scoreboard #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] m_rf [DP];
  bit            m_pend [DP];
  int            checks = 0;
  int            passed = 0;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle at negedge, check combinational outputs, then commit the model at posedge.
  task automatic applyStimulus(bit rst, bit we, int wa, logic [DW-1:0] wd,
                               bit re, int ra, int a1, int a2, bit chk);
    logic [DW-1:0] e1, e2;
    bit            b1, b2;
    int            cnt;
    @(negedge clk);
    rst_n        = rst;
    bus.wr_en    = we;
    bus.wr_addr  = AW'(wa);
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = AW'(ra);
    bus.rd_addr1 = AW'(a1);
    bus.rd_addr2 = AW'(a2);
    #1;
    if (chk) begin
      cnt = 0;
      for (int i = 0; i < DP; i++) cnt += int'(m_pend[i]);
      e1 = (a1 == 0) ? '0 : m_rf[a1];
      e2 = (a2 == 0) ? '0 : m_rf[a2];
      b1 = (a1 != 0) && m_pend[a1];
      b2 = (a2 != 0) && m_pend[a2];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && wa == a1 && a1 != 0) begin e1 = wd; b1 = 0; end
      if (we && wa == a2 && a2 != 0) begin e2 = wd; b2 = 0; end
`endif
      checkOutput($sformatf("rd_data1[%0d]", a1), 32'(bus.rd_data1), 32'(e1));
      checkOutput($sformatf("rd_data2[%0d]", a2), 32'(bus.rd_data2), 32'(e2));
      checkOutput($sformatf("busy1[%0d]", a1), 32'(bus.busy1), 32'(b1));
      checkOutput($sformatf("busy2[%0d]", a2), 32'(bus.busy2), 32'(b2));
      checkOutput("pend_cnt", 32'(bus.pend_cnt), 32'(cnt));
      checkOutput("idle", 32'(bus.idle), 32'(cnt == 0));
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < DP; i++) begin
        m_rf[i]   = '0;
        m_pend[i] = 0;
      end
    end else begin
      if (we && wa != 0) begin
        m_rf[wa]   = wd;
        m_pend[wa] = 0;
      end
      if (re && ra != 0) m_pend[ra] = 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    for (int i = 0; i < DP; i++) begin m_rf[i] = '0; m_pend[i] = 0; end

    // Reset, then read every address on both ports.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int a = 0; a < DP; a++) applyStimulus(1, 0, 0, 0, 0, 0, a, DP - 1 - a, 1);

    // Plain writes, including the ignored R0 write.
    applyStimulus(1, 1, 3, 24'hABCDEF, 0, 0, 3, 0, 1);
    applyStimulus(1, 1, 0, 24'hFFFFFF, 0, 0, 3, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3, 1);

    // Reserve then writeback.
    applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 1);
    applyStimulus(1, 1, 5, 24'h000123, 0, 0, 5, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 0, 1);

    // Same-address reserve + writeback on a pending register, then mixed reserve/clear.
    applyStimulus(1, 0, 0, 0, 1, 2, 2, 0, 1);
    applyStimulus(1, 1, 2, 24'h000055, 1, 2, 2, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 6, 2, 6, 1);
    applyStimulus(1, 1, 6, 24'h000066, 1, 4, 6, 4, 1);
    applyStimulus(1, 0, 0, 0, 1, 4, 6, 4, 1);

    // Reset mid-reservation with a write in flight.
    applyStimulus(1, 0, 0, 0, 1, 1, 1, 2, 1);
    applyStimulus(1, 0, 0, 0, 1, 2, 1, 2, 1);
    applyStimulus(1, 0, 0, 0, 1, 7, 7, 3, 1);
    applyStimulus(0, 1, 3, 24'h000777, 1, 5, 7, 3, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 7, 1);

    // Writeback to a pending register read on the same cycle.
    applyStimulus(1, 1, 4, 24'h111111, 1, 4, 0, 4, 1);
    applyStimulus(1, 1, 4, 24'h0F0F0F, 0, 0, 1, 4, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 4, 4, 1);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 39) != 0, 1'($urandom), $urandom_range(0, DP - 1),
                    DW'($urandom), 1'($urandom), $urandom_range(0, DP - 1),
                    $urandom_range(0, DP - 1), $urandom_range(0, DP - 1), 1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 2, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
